// File: rtl/prefix_sub_pkg.sv
// Shared types for the serial prefix subtractor: FSM states, digit count helper and
// the generate/propagate combine operator common to the prefix adder datapath.
package prefix_sub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int num_digits(input int width, input int digit);
      return width / digit;
   endfunction

   // hi covers the more significant span; same operator serves carry and borrow chains
   function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
      gp_t r;
      r.g = hi.g | (hi.p & lo.g);
      r.p = hi.p & lo.p;
      return r;
   endfunction

endpackage

// File: rtl/digit_borrow_prefix.sv
// Combinational DIGIT-wide Kogge-Stone borrow network: zero latency, no flow control.
// Resolves every bit borrow of one digit from the incoming digit borrow.
module digit_borrow_prefix
   import prefix_sub_pkg::*;
#(
   parameter int DIGIT = 8
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             borrow_in_d,
   output logic [DIGIT-1:0] diff_d,
   output logic             borrow_out_d,
   output logic             msb_borrow_in_d
);

   localparam int LEVELS = (DIGIT > 1) ? $clog2(DIGIT) : 0;

   logic [DIGIT-1:0] bin;

   always_comb begin
      gp_t cur [DIGIT];
      gp_t nxt [DIGIT];
      bin          = '0;
      diff_d       = '0;
      borrow_out_d = 1'b0;
      for (int i = 0; i < DIGIT; i++) begin
         cur[i].g = ~a_d[i] & b_d[i];
         cur[i].p = ~(a_d[i] ^ b_d[i]);
         nxt[i]   = cur[i];
      end
      // after level l, cur[i] spans bits [i : max(0, i-2^(l+1)+1)]
      for (int l = 0; l < LEVELS; l++) begin
         for (int i = 0; i < DIGIT; i++) begin
            if (i >= (1 << l)) begin
               nxt[i] = gp_combine(cur[i], cur[i - (1 << l)]);
            end else begin
               nxt[i] = cur[i];
            end
         end
         cur = nxt;
      end
      bin[0] = borrow_in_d;
      for (int i = 1; i < DIGIT; i++) begin
         bin[i] = cur[i-1].g | (cur[i-1].p & borrow_in_d);
      end
      diff_d       = a_d ^ b_d ^ bin;
      borrow_out_d = cur[DIGIT-1].g | (cur[DIGIT-1].p & borrow_in_d);
   end

   assign msb_borrow_in_d = bin[DIGIT-1];

endmodule

// File: rtl/serial_prefix_subtractor.sv
// Digit-serial A-B-borrow_in, LSD first; result valid NUM_DIGITS cycles after accept, one op in flight.
// DONE holds outputs while out_ready is low. Optional overflow output: PREFIX_SUB_OVERFLOW_EN.
module serial_prefix_subtractor
   import prefix_sub_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIGIT = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
`ifdef PREFIX_SUB_OVERFLOW_EN
   output logic             overflow,
`endif
   output logic             zero
);

   localparam int ND = num_digits(WIDTH, DIGIT);
   localparam int CW = (ND > 1) ? $clog2(ND) : 1;

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0 || (DIGIT & (DIGIT - 1)) != 0) begin : g_bad_cfg
      $error("serial_prefix_subtractor: DIGIT must be a power of two dividing WIDTH");
   end

   state_e           state_q;
   logic [WIDTH-1:0] a_q, b_q, diff_q;
   logic             brw_q;
   logic [CW-1:0]    cnt_q;
   logic             in_ready_q, out_valid_q, borrow_out_q, zero_q;

   logic [DIGIT-1:0]       dig_diff;
   logic                   dig_bo, dig_msb_bi;
   logic [WIDTH+DIGIT-1:0] diff_cat;
   logic [WIDTH-1:0]       diff_d;
   logic                   last_dig;

   digit_borrow_prefix #(.DIGIT(DIGIT)) u_prefix (
      .a_d             (a_q[DIGIT-1:0]),
      .b_d             (b_q[DIGIT-1:0]),
      .borrow_in_d     (brw_q),
      .diff_d          (dig_diff),
      .borrow_out_d    (dig_bo),
      .msb_borrow_in_d (dig_msb_bi)
   );

   // new digit enters at the MSB end so the first digit lands at the bottom
   assign diff_cat = {dig_diff, diff_q};
   assign diff_d   = diff_cat[WIDTH+DIGIT-1:DIGIT];
   assign last_dig = (cnt_q == CW'(ND - 1));

`ifdef PREFIX_SUB_OVERFLOW_EN
   logic overflow_q;
   assign overflow = overflow_q;
`else
   logic unused_msb_bi;
   assign unused_msb_bi = dig_msb_bi;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         diff_q       <= '0;
         brw_q        <= 1'b0;
         cnt_q        <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         borrow_out_q <= 1'b0;
         zero_q       <= 1'b0;
`ifdef PREFIX_SUB_OVERFLOW_EN
         overflow_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  a_q        <= a;
                  b_q        <= b;
                  brw_q      <= borrow_in;
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= RUN;
               end
            end
            RUN: begin
               a_q    <= a_q >> DIGIT;
               b_q    <= b_q >> DIGIT;
               diff_q <= diff_d;
               brw_q  <= dig_bo;
               cnt_q  <= cnt_q + CW'(1);
               if (last_dig) begin
                  state_q      <= DONE;
                  out_valid_q  <= 1'b1;
                  borrow_out_q <= dig_bo;
                  zero_q       <= (diff_d == '0);
`ifdef PREFIX_SUB_OVERFLOW_EN
                  overflow_q   <= dig_msb_bi ^ dig_bo;
`endif
               end
            end
            DONE: begin
               // in_ready rises only after the handoff edge, never alongside out_valid
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign zero       = zero_q;

endmodule
